spi_slave_param: RTL
====================

# spi_slave_param

Parametrised next-generation SPI slave: converts a serial MOSI frame of `DATA_W+2` bits (2-bit command + payload) into a parallel `rx_data` word with a one-cycle `rx_valid` strobe, and returns `DATA_W`-bit read data on MISO after a `tx_valid` handshake. It sits between an external SPI master (SS_n/MOSI/MISO, sampled on the system clock, one bit per `clk`) and the single-port RAM controller that decodes the command bits. Over the previous slave it adds:
- width generalisation;
- optional input synchronisers;
- deterministic read-address/read-data sequencing;
- explicit tx handshake;
- abort detection.

## Interface
Parameters:
- `DATA_W`, 8, payload width; legal 4..16; frame width `W = DATA_W+2`.
- `SYNC_STAGES`, 0, flops on SS_n and MOSI before use; legal 0 or 2.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `SS_n`  in  1  slave select, active low.
- `MOSI`  in  1  serial data in, MSB first.
- `MISO`  out  1  serial read data out, MSB first.
- `rx_data`  out  W  last complete frame; `[W-1:W-2]` command, `[DATA_W-1:0]` payload.
- `rx_valid`  out  1  one-cycle strobe, `rx_data` valid.
- `tx_data`  in  DATA_W  read data from RAM.
- `tx_valid`  in  1  `tx_data` valid; sampled only while awaiting read data.
- `busy`  out  1  high whenever state is not IDLE.
- `frame_err`  out  1  one-cycle strobe on SS_n rise before frame/read completes.

## Operation
- Commands: 00 WR_ADDR, 01 WR_DATA, 10 RD_ADDR, 11 RD_DATA.
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA. Internal `rd_addr_seen` flag, reset 0.
- IDLE: SS_n=0 → CHK_CMD.
- CHK_CMD: samples frame bit 0 (MSB) from MOSI into the shift register.
  - MOSI=0 → WRITE.
  - MOSI=1 and `rd_addr_seen`=0 → READ_ADD.
  - MOSI=1 and `rd_addr_seen`=1 → READ_DATA.
  - SS_n=1 → IDLE.
- WRITE / READ_ADD / READ_DATA: shift bits 1..W-1, one per `clk`. On the edge sampling bit W-1, `rx_data` is loaded and `rx_valid`=1 for exactly one cycle.
- READ_ADD: frame completion sets `rd_addr_seen`.
- READ_DATA: after `rx_valid`, waits for `tx_valid`.
  - Latches `tx_data` on the first `clk` with `tx_valid`=1.
  - Drives MISO with `tx_data[DATA_W-1]` at the next edge, then one bit per edge, `DATA_W` bits total.
  - MISO returns to 0 after the last bit; `rd_addr_seen` clears when the last bit is driven.
- After frame/read completion, the block stays in its state, ignoring MOSI, until SS_n=1 → IDLE. A new frame requires SS_n to toggle high.
- Abort: SS_n=1 in any non-IDLE state before completion → IDLE next edge.
  - `frame_err` pulses; no `rx_valid`; `rd_addr_seen` unchanged; MISO forced 0.
- Bit counter is `$clog2(W+1)` wide, cleared in CHK_CMD, never wraps within a frame.

## Timing
- Reset values: state IDLE, MISO 0, `rx_valid` 0, `rx_data` 0, `busy` 0, `frame_err` 0, `rd_addr_seen` 0, counters 0.
- Reset mid-frame: immediate return to reset values; the partial frame is discarded.
- `SYNC_STAGES`=2 adds 2 cycles to every latency below.
- Latencies:
  - Edge N samples SS_n=0 → CHK_CMD at N+1.
  - Bit 0 sampled at edge N+1; bit W-1 at N+W.
  - `rx_valid` high in cycle N+W..N+W+1.
- `tx_valid` latched at edge T → MISO bit `DATA_W-1` valid after edge T+1; last bit after edge T+DATA_W.
- `tx_valid` asserted before the READ_DATA `rx_valid` is ignored. `tx_valid` may be a pulse or held; only the first accepted cycle counts.
- Simultaneous SS_n rise and last-bit sample: the frame completes (`rx_valid`=1, no `frame_err`), then IDLE.

## Structure
- Package `spi_slave_pkg` holds:
  - the state enum (sequential encoding);
  - command code constants;
  - the `W` frame-width helper function.
- Sub-module `spi_sync`: N-stage synchroniser, instantiated for SS_n and MOSI when `SYNC_STAGES`>0.
- Single FSM plus datapath (shift register, bit counter, tx shift register) in the top module.

## Test plan
- WR_ADDR, `DATA_W`=8, frame 00_10100101 → `rx_valid` one cycle, `rx_data`=0x0A5, W cycles after CHK_CMD; MISO stays 0.
- RD_ADDR 10_00001111, then new SS_n frame 11_00000000 → second frame enters READ_DATA. `tx_valid` with `tx_data`=0xC3 → MISO 1,1,0,0,0,0,1,1 on consecutive edges; `rd_addr_seen` clears.
- RD_DATA frame sent with `rd_addr_seen`=0 → routed to READ_ADD, sets flag, no MISO activity.
- SS_n rises after 5 of 10 bits → `frame_err` one cycle; no `rx_valid`; IDLE next edge; next frame decodes correctly.
- `DATA_W`=12, `SYNC_STAGES`=2 → 14-bit frame 01_0xABC → `rx_data`=0x1ABC, latency +2 cycles.
- `rst_n` low mid-read shift → MISO 0, `busy` 0 asynchronously; all outputs at reset values.

Source files
------------

// File: rtl/spi_slave_pkg.sv
// Shared types and constants for the parametrised SPI slave:
// FSM state encoding, command codes and the frame-width helper.
package spi_slave_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CHK_CMD   = 3'd1,
    ST_WRITE     = 3'd2,
    ST_READ_ADD  = 3'd3,
    ST_READ_DATA = 3'd4
  } state_e;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  function automatic int frame_w(input int data_w);
    return data_w + 32'sd2;
  endfunction

endpackage

// File: rtl/spi_slave_param_sync.sv
// N-stage flop synchroniser with a selectable reset level, used on the
// asynchronous SPI inputs before they reach the slave FSM.
module spi_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff_q;
  logic [STAGES-1:0] ff_d;

  // shift the raw input one stage further down the chain
  always_comb begin
    ff_d    = ff_q << 1;
    ff_d[0] = d;
  end

  // synchroniser flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff_q <= {STAGES{RST_VAL}};
    end else begin
      ff_q <= ff_d;
    end
  end

  assign q = ff_q[STAGES-1];

endmodule

// File: rtl/spi_slave_param.sv
// Parametrised SPI slave: deserialises command+payload frames, sequences
// read-address/read-data frames and shifts RAM read data out on MISO.
module spi_slave_param
  import spi_slave_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SS_n,
  input  logic              MOSI,
  output logic              MISO,
  output logic [DATA_W+1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              busy,
  output logic              frame_err
);

  localparam int W        = frame_w(DATA_W);
  localparam int CNT_W    = $clog2(W + 1);
  localparam int TX_CNT_W = $clog2(DATA_W + 1);

  logic ss_n_s;
  logic mosi_s;

  generate
    if (SYNC_STAGES > 0) begin : g_sync
      spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
        .clk(clk), .rst_n(rst_n), .d(SS_n), .q(ss_n_s)
      );
      spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst_n(rst_n), .d(MOSI), .q(mosi_s)
      );
    end else begin : g_nosync
      assign ss_n_s = SS_n;
      assign mosi_s = MOSI;
    end
  endgenerate

  state_e              state_q, state_d;
  logic [W-2:0]        sr_q, sr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [W-1:0]        rx_data_q, rx_data_d;
  logic                rx_valid_q, rx_valid_d;
  logic                frame_err_q, frame_err_d;
  logic                busy_q, busy_d;
  logic                miso_q, miso_d;
  logic                rd_seen_q, rd_seen_d;
  logic                done_q, done_d;
  logic                tx_wait_q, tx_wait_d;
  logic                tx_act_q, tx_act_d;
  logic [DATA_W-1:0]   tx_sr_q, tx_sr_d;
  logic [TX_CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic                last_bit_s;

  assign last_bit_s = (cnt_q == CNT_W'(W - 2));

  // next-state and datapath decode; done_q marks a finished frame or read
  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    cnt_d       = cnt_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    miso_d      = 1'b0;
    rd_seen_d   = rd_seen_q;
    done_d      = done_q;
    tx_wait_d   = tx_wait_q;
    tx_act_d    = tx_act_q;
    tx_sr_d     = tx_sr_q;
    tx_cnt_d    = tx_cnt_q;
    case (state_q)
      ST_IDLE: begin
        done_d    = 1'b0;
        tx_wait_d = 1'b0;
        tx_act_d  = 1'b0;
        if (!ss_n_s) begin
          state_d = ST_CHK_CMD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CHK_CMD: begin
        if (ss_n_s) begin
          state_d     = ST_IDLE;
          frame_err_d = 1'b1;
        end else begin
          sr_d  = {{(W-2){1'b0}}, mosi_s};
          cnt_d = {CNT_W{1'b0}};
          if (mosi_s == CMD_RD_ADDR[1]) begin
            state_d = rd_seen_q ? ST_READ_DATA : ST_READ_ADD;
          end else begin
            state_d = ST_WRITE;
          end
        end
      end
      ST_WRITE, ST_READ_ADD, ST_READ_DATA: begin
        if (done_q) begin
          if (ss_n_s) begin
            state_d = ST_IDLE;
          end else begin
            state_d = state_q;
          end
        end else if (!tx_wait_q && !tx_act_q) begin
          // a rise coinciding with the last bit still completes the frame
          if (last_bit_s) begin
            rx_data_d  = {sr_q, mosi_s};
            rx_valid_d = 1'b1;
            if (state_q == ST_READ_ADD) begin
              rd_seen_d = 1'b1;
            end else begin
              rd_seen_d = rd_seen_q;
            end
            if (ss_n_s) begin
              state_d = ST_IDLE;
            end else if (state_q == ST_READ_DATA) begin
              tx_wait_d = 1'b1;
            end else begin
              done_d = 1'b1;
            end
          end else if (ss_n_s) begin
            state_d     = ST_IDLE;
            frame_err_d = 1'b1;
          end else begin
            sr_d  = {sr_q[W-3:0], mosi_s};
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else if (ss_n_s) begin
          state_d     = ST_IDLE;
          frame_err_d = 1'b1;
        end else if (tx_wait_q) begin
          if (tx_valid) begin
            tx_sr_d   = tx_data;
            tx_cnt_d  = TX_CNT_W'(DATA_W);
            tx_wait_d = 1'b0;
            tx_act_d  = 1'b1;
          end else begin
            tx_wait_d = 1'b1;
          end
        end else begin
          miso_d   = tx_sr_q[DATA_W-1];
          tx_sr_d  = {tx_sr_q[DATA_W-2:0], 1'b0};
          tx_cnt_d = tx_cnt_q - TX_CNT_W'(1);
          if (tx_cnt_q == TX_CNT_W'(1)) begin
            rd_seen_d = 1'b0;
            done_d    = 1'b1;
            tx_act_d  = 1'b0;
          end else begin
            tx_act_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      sr_q        <= '0;
      cnt_q       <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
      miso_q      <= 1'b0;
      rd_seen_q   <= 1'b0;
      done_q      <= 1'b0;
      tx_wait_q   <= 1'b0;
      tx_act_q    <= 1'b0;
      tx_sr_q     <= '0;
      tx_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      cnt_q       <= cnt_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
      miso_q      <= miso_d;
      rd_seen_q   <= rd_seen_d;
      done_q      <= done_d;
      tx_wait_q   <= tx_wait_d;
      tx_act_q    <= tx_act_d;
      tx_sr_q     <= tx_sr_d;
      tx_cnt_q    <= tx_cnt_d;
    end
  end

  assign MISO      = miso_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign busy      = busy_q;
  assign frame_err = frame_err_q;

endmodule
